alu_seq: RTL and testbench

- Multi-cycle, parametrised successor to the calculator's combinational ALU.
- Performs signed-magnitude add, subtract, multiply and divide on binary magnitudes of BCDdigits*4 bits.
- Multiply is iterative shift-add; divide is iterative restoring division.
- Sits between the calculator's operand/operator capture logic and the result display path, and exchanges data with both over a valid/ready handshake.

---
 rtl/alu_seq_if.sv | 43 ++++
 rtl/alu_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/result bus of the sequential calculator ALU.
// Build option: define ALU_SEQ_REMAINDER_EN to add the divide remainder signal.
interface alu_seq_if #(
  parameter int BCDdigits = 2
);
  localparam int W = BCDdigits * 4;

  logic           in_valid;
  logic           in_ready;
  logic [3:0]     operator;
  logic           op1_sign;
  logic           op2_sign;
  logic [W-1:0]   operand1;
  logic [W-1:0]   operand2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           sign;
  logic [1:0]     err;
`ifdef ALU_SEQ_REMAINDER_EN
  logic [W-1:0]   remainder;
`endif

`ifdef ALU_SEQ_REMAINDER_EN
  modport master (
    output in_valid, operator, op1_sign, op2_sign, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, sign, err, remainder
  );
  modport slave (
    input  in_valid, operator, op1_sign, op2_sign, operand1, operand2, out_ready,
    output in_ready, out_valid, result, sign, err, remainder
  );
`else
  modport master (
    output in_valid, operator, op1_sign, op2_sign, operand1, operand2, out_ready,
    input  in_ready, out_valid, result, sign, err
  );
  modport slave (
    input  in_valid, operator, op1_sign, op2_sign, operand1, operand2, out_ready,
    output in_ready, out_valid, result, sign, err
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle signed-magnitude ALU: add/sub in one cycle, iterative shift-add
// multiply and restoring divide over W = BCDdigits*4 steps.
// Build option: ALU_SEQ_REMAINDER_EN exposes the divide remainder on the bus.
module alu_seq #(
  parameter int         BCDdigits = 2,
  parameter logic [3:0] PLUS      = 4'd10,
  parameter logic [3:0] SUBTRACT  = 4'd11,
  parameter logic [3:0] MUL       = 4'd12,
  parameter logic [3:0] DIV       = 4'd13
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int W  = BCDdigits * 4;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvsr_q, dvsr_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           psign_q, psign_d;
  logic [2*W-1:0] result_q, result_d;
  logic           sign_q, sign_d;
  logic [1:0]     err_q, err_d;
`ifdef ALU_SEQ_REMAINDER_EN
  logic [W-1:0]   remo_q, remo_d;
`endif

  logic           accept;
  logic           last;
  logic [2*W-1:0] acc_step;
  logic [W:0]     div_shift;
  logic [W-1:0]   rem_new;
  logic [W-1:0]   quo_new;
  logic [2*W:0]   addsub_res;

  // A zero magnitude never carries a negative sign.
  function automatic logic fix_sign(input logic s, input logic [2*W-1:0] mag);
    return s & (mag != '0);
  endfunction

  // Signed-magnitude addition; returns {sign, magnitude}.
  function automatic logic [2*W:0] addsub(input logic s1, input logic s2,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ae, be, mag;
    logic           s;
    ae = {{W{1'b0}}, a};
    be = {{W{1'b0}}, b};
    if (s1 == s2) begin
      mag = ae + be;
      s   = s1;
    end else if (a >= b) begin
      mag = ae - be;
      s   = s1;
    end else begin
      mag = be - ae;
      s   = s2;
    end
    return {fix_sign(s, mag), mag};
  endfunction

  assign accept = (state_q == S_IDLE) && bus.in_valid;
  assign last   = (cnt_q == CW'(W - 1));

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          case (bus.operator)
            MUL:     state_d = S_MUL;
            DIV:     state_d = (bus.operand2 != '0) ? S_DIV : S_DONE;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_MUL:   if (last) state_d = S_DONE;
      S_DIV:   if (last) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  // One shift-add step and one restoring-division step, computed every cycle.
  always_comb begin
    acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    div_shift = {rem_q, quo_q[W-1]};
    if (div_shift >= {1'b0, dvsr_q}) begin
      rem_new = W'(div_shift - {1'b0, dvsr_q});
      quo_new = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_new = div_shift[W-1:0];
      quo_new = {quo_q[W-2:0], 1'b0};
    end
    addsub_res = addsub(bus.op1_sign,
                        (bus.operator == SUBTRACT) ? ~bus.op2_sign : bus.op2_sign,
                        bus.operand1, bus.operand2);
  end

  // Datapath next-state: capture on accept, iterate, latch the result into DONE.
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    psign_d  = psign_q;
    result_d = result_q;
    sign_d   = sign_q;
    err_d    = err_q;
`ifdef ALU_SEQ_REMAINDER_EN
    remo_d   = remo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          mcand_d  = {{W{1'b0}}, bus.operand1};
          mplier_d = bus.operand2;
          acc_d    = '0;
          quo_d    = bus.operand1;
          dvsr_d   = bus.operand2;
          rem_d    = '0;
          psign_d  = bus.op1_sign ^ bus.op2_sign;
          case (bus.operator)
            PLUS, SUBTRACT: begin
              result_d = addsub_res[2*W-1:0];
              sign_d   = addsub_res[2*W];
              err_d    = 2'd0;
`ifdef ALU_SEQ_REMAINDER_EN
              remo_d   = '0;
`endif
            end
            MUL, DIV: begin
              if (bus.operator == DIV && bus.operand2 == '0) begin
                result_d = '0;
                sign_d   = 1'b0;
                err_d    = 2'd1;
`ifdef ALU_SEQ_REMAINDER_EN
                remo_d   = '0;
`endif
              end
            end
            default: begin
              result_d = '0;
              sign_d   = 1'b0;
              err_d    = 2'd2;
`ifdef ALU_SEQ_REMAINDER_EN
              remo_d   = '0;
`endif
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[2*W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[W-1:1]};
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          cnt_d    = '0;
          result_d = acc_step;
          sign_d   = fix_sign(psign_q, acc_step);
          err_d    = 2'd0;
`ifdef ALU_SEQ_REMAINDER_EN
          remo_d   = '0;
`endif
        end
      end
      S_DIV: begin
        rem_d = rem_new;
        quo_d = quo_new;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          cnt_d    = '0;
          result_d = {{W{1'b0}}, quo_new};
          sign_d   = fix_sign(psign_q, {{W{1'b0}}, quo_new});
          err_d    = 2'd0;
`ifdef ALU_SEQ_REMAINDER_EN
          remo_d   = rem_new;
`endif
        end
      end
      default: ;
    endcase
  end

  // Visible results and the step counter are cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      result_q <= '0;
      sign_q   <= 1'b0;
      err_q    <= 2'd0;
`ifdef ALU_SEQ_REMAINDER_EN
      remo_q   <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_REMAINDER_EN
      remo_q   <= remo_d;
`endif
    end
  end

  // Working registers of the iterative units; always loaded before use.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    quo_q    <= quo_d;
    dvsr_q   <= dvsr_d;
    rem_q    <= rem_d;
    psign_q  <= psign_d;
  end

  assign bus.result = result_q;
  assign bus.sign   = sign_q;
  assign bus.err    = err_q;
`ifdef ALU_SEQ_REMAINDER_EN
  assign bus.remainder = remo_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (BCDdigits = 2, W = 8).
module tb_alu_seq;
  localparam int W = 8;
  localparam logic [3:0] OP_ADD = 4'd10;
  localparam logic [3:0] OP_SUB = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_DIV = 4'd13;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_seq_if #(.BCDdigits(2)) bus ();

  alu_seq #(.BCDdigits(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, scramble the inputs after the accept edge, and count
  // cycles until out_valid (1 = visible right after the accepting edge).
  task automatic run_op(input logic [3:0] op, input logic s1, input logic s2,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_bad);
    bus.operator = op;
    bus.op1_sign = s1;
    bus.op2_sign = s2;
    bus.operand1 = a;
    bus.operand2 = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.operator = 4'd10;
    bus.op1_sign = ~s1;
    bus.op2_sign = ~s2;
    bus.operand1 = ~a;
    bus.operand2 = ~b;
    lat      = 1;
    busy_bad = 0;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      if (bus.in_ready !== 1'b0) busy_bad++;
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    total++;
    if (bus.result !== 16'd0 || bus.sign !== 1'b0 || bus.err !== 2'd0) begin
      bad++;
      $display("FAIL reset_out: result=%0d sign=%b err=%0d want 0/0/0", bus.result, bus.sign, bus.err);
    end
`ifdef ALU_SEQ_REMAINDER_EN
    total++;
    if (bus.remainder !== 8'd0) begin
      bad++;
      $display("FAIL reset_rem: remainder=%0d want 0", bus.remainder);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int lat, bb;
    run_op(OP_ADD, 1'b0, 1'b1, 8'd25, 8'd40, lat, bb);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL add_lat: got %0d want 1", lat); end
    total++;
    if (bus.result !== 16'd15 || bus.sign !== 1'b1 || bus.err !== 2'd0) begin
      bad++;
      $display("FAIL add_val: result=%0d sign=%b err=%0d want 15/1/0", bus.result, bus.sign, bus.err);
    end
    consume();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL add_consume: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_sub_zero();
    int lat, bb;
    run_op(OP_SUB, 1'b1, 1'b1, 8'd7, 8'd7, lat, bb);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL sub_lat: got %0d want 1", lat); end
    total++;
    if (bus.result !== 16'd0 || bus.sign !== 1'b0 || bus.err !== 2'd0) begin
      bad++;
      $display("FAIL sub_zero: result=%0d sign=%b err=%0d want 0/0/0", bus.result, bus.sign, bus.err);
    end
    consume();
    // -12 - (+30) = -42
    run_op(OP_SUB, 1'b1, 1'b0, 8'd12, 8'd30, lat, bb);
    total++;
    if (bus.result !== 16'd42 || bus.sign !== 1'b1) begin
      bad++;
      $display("FAIL sub_val: result=%0d sign=%b want 42/1", bus.result, bus.sign);
    end
    consume();
  endtask

  task automatic test_mul();
    int lat, bb;
    run_op(OP_MUL, 1'b1, 1'b0, 8'd255, 8'd255, lat, bb);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL mul_lat: got %0d want 9", lat); end
    total++;
    if (bb !== 0) begin bad++; $display("FAIL mul_busy: in_ready high %0d cycles want 0", bb); end
    total++;
    if (bus.result !== 16'd65025 || bus.sign !== 1'b1 || bus.err !== 2'd0) begin
      bad++;
      $display("FAIL mul_val: result=%0d sign=%b err=%0d want 65025/1/0", bus.result, bus.sign, bus.err);
    end
`ifdef ALU_SEQ_REMAINDER_EN
    total++;
    if (bus.remainder !== 8'd0) begin bad++; $display("FAIL mul_rem: got %0d want 0", bus.remainder); end
`endif
    consume();
    // -13 * 0 = 0 with the sign forced positive
    run_op(OP_MUL, 1'b1, 1'b0, 8'd13, 8'd0, lat, bb);
    total++;
    if (bus.result !== 16'd0 || bus.sign !== 1'b0) begin
      bad++;
      $display("FAIL mul_zero: result=%0d sign=%b want 0/0", bus.result, bus.sign);
    end
    consume();
  endtask

  task automatic test_div();
    int lat, bb;
    run_op(OP_DIV, 1'b1, 1'b0, 8'd200, 8'd7, lat, bb);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL div_lat: got %0d want 9", lat); end
    total++;
    if (bus.result !== 16'd28 || bus.sign !== 1'b1 || bus.err !== 2'd0) begin
      bad++;
      $display("FAIL div_val: result=%0d sign=%b err=%0d want 28/1/0", bus.result, bus.sign, bus.err);
    end
`ifdef ALU_SEQ_REMAINDER_EN
    total++;
    if (bus.remainder !== 8'd4) begin bad++; $display("FAIL div_rem: got %0d want 4", bus.remainder); end
`endif
    consume();
    // -5 / 9 truncates to 0, sign forced positive
    run_op(OP_DIV, 1'b1, 1'b0, 8'd5, 8'd9, lat, bb);
    total++;
    if (bus.result !== 16'd0 || bus.sign !== 1'b0) begin
      bad++;
      $display("FAIL div_small: result=%0d sign=%b want 0/0", bus.result, bus.sign);
    end
    consume();
  endtask

  task automatic test_errors();
    int lat, bb;
    run_op(OP_DIV, 1'b0, 1'b1, 8'd50, 8'd0, lat, bb);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL dz_lat: got %0d want 1", lat); end
    total++;
    if (bus.result !== 16'd0 || bus.sign !== 1'b0 || bus.err !== 2'd1) begin
      bad++;
      $display("FAIL dz_val: result=%0d sign=%b err=%0d want 0/0/1", bus.result, bus.sign, bus.err);
    end
`ifdef ALU_SEQ_REMAINDER_EN
    total++;
    if (bus.remainder !== 8'd0) begin bad++; $display("FAIL dz_rem: got %0d want 0", bus.remainder); end
`endif
    consume();
    run_op(4'd3, 1'b1, 1'b0, 8'd9, 8'd4, lat, bb);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL ill_lat: got %0d want 1", lat); end
    total++;
    if (bus.result !== 16'd0 || bus.sign !== 1'b0 || bus.err !== 2'd2) begin
      bad++;
      $display("FAIL ill_val: result=%0d sign=%b err=%0d want 0/0/2", bus.result, bus.sign, bus.err);
    end
    consume();
  endtask

  task automatic test_hold();
    int lat, bb, unstable;
    run_op(OP_ADD, 1'b0, 1'b0, 8'd99, 8'd1, lat, bb);
    unstable = 0;
    bus.operator = OP_MUL;
    bus.operand1 = 8'd3;
    bus.operand2 = 8'd3;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 16'd100 ||
          bus.sign !== 1'b0 || bus.err !== 2'd0) unstable++;
    end
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL hold: %0d unstable cycles want 0", unstable); end
    bus.in_valid = 1'b0;
    consume();
    tick();
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || bus.result !== 16'd100) begin
      bad++;
      $display("FAIL hold_ignored: out_valid=%b result=%0d want 0/100", bus.out_valid, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    run_op(OP_ADD, 1'b0, 1'b0, 8'd1, 8'd2, lat, bb);
    consume();
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", bus.in_ready); end
    run_op(OP_MUL, 1'b0, 1'b0, 8'd12, 8'd11, lat, bb);
    total++;
    if (lat !== 9 || bus.result !== 16'd132 || bus.sign !== 1'b0) begin
      bad++;
      $display("FAIL b2b_mul: lat=%0d result=%0d sign=%b want 9/132/0", lat, bus.result, bus.sign);
    end
    consume();
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    bus.operator = OP_MUL;
    bus.op1_sign = 1'b0;
    bus.op2_sign = 1'b0;
    bus.operand1 = 8'd20;
    bus.operand2 = 8'd30;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 16'd0) begin
      bad++;
      $display("FAIL rst_mul: out_valid=%b in_ready=%b result=%0d want 0/1/0",
               bus.out_valid, bus.in_ready, bus.result);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rst_abort: out_valid seen %0d cycles want 0", seen); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.operator  = 4'd0;
    bus.op1_sign  = 1'b0;
    bus.op2_sign  = 1'b0;
    bus.operand1  = '0;
    bus.operand2  = '0;
    test_reset();
    test_add();
    test_sub_zero();
    test_mul();
    test_div();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
